// File: rtl/cvxif_resp_pkg.sv
// cvxif_resp_pkg: decode constants, op enum and in-flight entry type shared by the responder.
// Optional MUL support is enabled by defining CVXIF_RESP_MUL_EN.
package cvxif_resp_pkg;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b001;
  localparam logic [2:0] F3_NOP = 3'b010;
  localparam logic [2:0] F3_MUL = 3'b011;
`ifdef CVXIF_RESP_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  // encoding matches funct3[1:0] so decode is a plain cast
  typedef enum logic [1:0] {OP_ADD, OP_XOR, OP_NOP, OP_MUL} op_e;
  typedef struct packed {
    logic       valid;
    logic       dead;
    logic       have_ops;
    logic       committed;
    op_e        op;
    logic [4:0] rd;
  } entry_t;
  function automatic logic accepted(input logic [6:0] opcode, input logic [6:0] funct7,
                                    input logic [2:0] funct3);
    return opcode == OPC_CUSTOM0 && funct7 == 7'd0 &&
           (funct3 == F3_ADD || funct3 == F3_XOR || funct3 == F3_NOP || (MUL_EN && funct3 == F3_MUL));
  endfunction
endpackage

// File: rtl/cvxif_resp_alu.sv
// cvxif_resp_alu: combinational result datapath (ADD/XOR, MUL when CVXIF_RESP_MUL_EN).
// Ports: op selects the operation, a/b operands, y result (low XLEN bits).
module cvxif_resp_alu
  import cvxif_resp_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  op_e             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
`ifdef CVXIF_RESP_MUL_EN
  always_comb y = op == OP_MUL ? a * b : op == OP_XOR ? a ^ b : a + b;
`else
  always_comb y = op == OP_XOR ? a ^ b : a + b;
`endif
endmodule

// File: rtl/cvxif_issue_responder.sv
// cvxif_issue_responder: CV-X-IF coprocessor answering custom-0 ADD/XOR/NOP (MUL with CVXIF_RESP_MUL_EN).
// Ports: clk_i/rst_ni (sync, active-low); x_issue_* accept/decode; x_register_* operands;
// x_commit_* commit/kill; x_result_* in-order result beats.
module cvxif_issue_responder
  import cvxif_resp_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            x_issue_valid_i,
  output logic            x_issue_ready_o,
  input  logic [31:0]     x_issue_instr_i,
  input  logic [ID_W-1:0] x_issue_id_i,
  output logic            x_issue_accept_o,
  output logic            x_issue_writeback_o,
  input  logic            x_register_valid_i,
  output logic            x_register_ready_o,
  input  logic [ID_W-1:0] x_register_id_i,
  input  logic [XLEN-1:0] x_register_rs1_i,
  input  logic [XLEN-1:0] x_register_rs2_i,
  input  logic            x_commit_valid_i,
  input  logic [ID_W-1:0] x_commit_id_i,
  input  logic            x_commit_kill_i,
  output logic            x_result_valid_o,
  input  logic            x_result_ready_i,
  output logic [ID_W-1:0] x_result_id_o,
  output logic [XLEN-1:0] x_result_data_o,
  output logic [4:0]      x_result_rd_o,
  output logic            x_result_we_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  entry_t          ent  [DEPTH];
  logic [ID_W-1:0] ids  [DEPTH];
  logic [XLEN-1:0] op_a [DEPTH];
  logic [XLEN-1:0] op_b [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [PW:0]     count;
  entry_t          h;
  op_e             dec_op;
  logic            dec_ok, issue_fire, pop, load, res_free, unused_ok;
  logic [XLEN-1:0] alu_y;
  assign unused_ok = ^x_issue_instr_i[24:15];
  always_comb begin
    dec_op     = op_e'(x_issue_instr_i[13:12]);
    dec_ok     = accepted(x_issue_instr_i[6:0], x_issue_instr_i[31:25], x_issue_instr_i[14:12]);
    issue_fire = x_issue_valid_i && x_issue_ready_o && dec_ok;
    h          = ent[head];
    res_free   = !x_result_valid_o || x_result_ready_i;
    // dead heads and NOPs leave without touching the result register
    pop        = h.valid && (h.dead || (h.have_ops && h.committed && (h.op == OP_NOP || res_free)));
    load       = pop && !h.dead && h.op != OP_NOP;
  end
  assign x_issue_ready_o     = count < FULL;
  assign x_issue_accept_o    = x_issue_valid_i && dec_ok;
  assign x_issue_writeback_o = x_issue_accept_o && dec_op != OP_NOP;
  assign x_register_ready_o  = 1'b1;
  cvxif_resp_alu #(.XLEN(XLEN)) u_alu (.op(h.op), .a(op_a[head]), .b(op_b[head]), .y(alu_y));
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i]  <= '0;
        ids[i]  <= '0;
        op_a[i] <= '0;
        op_b[i] <= '0;
      end
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      x_result_valid_o <= 1'b0;
      x_result_id_o    <= '0;
      x_result_data_o  <= '0;
      x_result_rd_o    <= '0;
      x_result_we_o    <= 1'b0;
    end else begin
      // the entry being allocated this cycle is not yet valid, so same-cycle register/commit miss it
      for (int i = 0; i < DEPTH; i++) begin
        if (x_register_valid_i && ent[i].valid && !ent[i].dead && ids[i] == x_register_id_i) begin
          op_a[i]         <= x_register_rs1_i;
          op_b[i]         <= x_register_rs2_i;
          ent[i].have_ops <= 1'b1;
        end
        if (x_commit_valid_i && ent[i].valid && !ent[i].dead && ids[i] == x_commit_id_i) begin
          if (x_commit_kill_i) ent[i].dead <= 1'b1;
          else ent[i].committed <= 1'b1;
        end
      end
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      if (issue_fire) begin
        ent[tail] <= '{valid: 1'b1, dead: 1'b0, have_ops: 1'b0, committed: 1'b0,
                       op: dec_op, rd: x_issue_instr_i[11:7]};
        ids[tail] <= x_issue_id_i;
        tail      <= tail + 1'b1;
      end
      count <= count + (PW+1)'(issue_fire) - (PW+1)'(pop);
      if (load) begin
        x_result_valid_o <= 1'b1;
        x_result_id_o    <= ids[head];
        x_result_data_o  <= alu_y;
        x_result_rd_o    <= h.rd;
        x_result_we_o    <= 1'b1;
      end else if (x_result_ready_i) x_result_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cvxif_issue_responder.sv
// tb_cvxif_issue_responder: directed self-checking bench for cvxif_issue_responder (default parameters).
module tb_cvxif_issue_responder;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        x_issue_valid_i = 0, x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o;
  logic [31:0] x_issue_instr_i = '0;
  logic [3:0]  x_issue_id_i = '0;
  logic        x_register_valid_i = 0, x_register_ready_o;
  logic [3:0]  x_register_id_i = '0;
  logic [63:0] x_register_rs1_i = '0, x_register_rs2_i = '0;
  logic        x_commit_valid_i = 0, x_commit_kill_i = 0;
  logic [3:0]  x_commit_id_i = '0;
  logic        x_result_valid_o, x_result_ready_i = 1, x_result_we_o;
  logic [3:0]  x_result_id_o;
  logic [63:0] x_result_data_o;
  logic [4:0]  x_result_rd_o;
  int checks = 0, errors = 0;
  logic acc, wb;
  typedef struct {logic [3:0] id; logic [4:0] rd; logic [63:0] data; logic we;} beat_t;
  beat_t beats[$];

  always #5 clk = ~clk;

  cvxif_issue_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
    .x_issue_instr_i(x_issue_instr_i), .x_issue_id_i(x_issue_id_i),
    .x_issue_accept_o(x_issue_accept_o), .x_issue_writeback_o(x_issue_writeback_o),
    .x_register_valid_i(x_register_valid_i), .x_register_ready_o(x_register_ready_o),
    .x_register_id_i(x_register_id_i), .x_register_rs1_i(x_register_rs1_i),
    .x_register_rs2_i(x_register_rs2_i),
    .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
    .x_commit_kill_i(x_commit_kill_i),
    .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
    .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
    .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o)
  );

  // a beat seen valid&ready here completes at the following posedge
  always begin
    @(negedge clk);
    #1;
    if (rst_ni && x_result_valid_o && x_result_ready_i)
      beats.push_back(beat_t'{x_result_id_o, x_result_rd_o, x_result_data_o, x_result_we_o});
  end

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 10'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [3:0] id);
    x_issue_valid_i = 1; x_issue_instr_i = ins; x_issue_id_i = id;
    #1 acc = x_issue_accept_o; wb = x_issue_writeback_o;
    @(negedge clk);
    x_issue_valid_i = 0;
  endtask

  task automatic regs(input logic [3:0] id, input logic [63:0] a, input logic [63:0] b);
    x_register_valid_i = 1; x_register_id_i = id; x_register_rs1_i = a; x_register_rs2_i = b;
    @(negedge clk);
    x_register_valid_i = 0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    x_commit_valid_i = 1; x_commit_id_i = id; x_commit_kill_i = kill;
    @(negedge clk);
    x_commit_valid_i = 0; x_commit_kill_i = 0;
  endtask

  task automatic do_reset;
    rst_ni = 0;
    tick(1);
    rst_ni = 1;
  endtask

  task automatic expect_beat(input string tag, input logic [3:0] id, input logic [4:0] rd,
                             input logic [63:0] data);
    beat_t b;
    check({tag, "_present"}, 64'(beats.size() > 0), 1);
    if (beats.size() > 0) begin
      b = beats.pop_front();
      check({tag, "_id"}, b.id, id);
      check({tag, "_rd"}, b.rd, rd);
      check({tag, "_data"}, b.data, data);
      check({tag, "_we"}, b.we, 1);
    end
  endtask

  initial begin
    tick(2);
    check("rst_ready", x_issue_ready_o, 1);
    check("rst_valid", x_result_valid_o, 0);
    check("rst_reg_ready", x_register_ready_o, 1);
    rst_ni = 1;
    tick(1);
    // basic ADD with one-cycle retire latency
    issue(enc(3'b000, 5'd5), 4'd3);
    check("add_acc", acc, 1);
    check("add_wb", wb, 1);
    regs(4'd3, 64'd7, 64'd9);
    commit(4'd3, 0);
    check("add_lat0", x_result_valid_o, 0);
    tick(1);
    check("add_lat1", x_result_valid_o, 1);
    tick(1);
    check("add_drop", x_result_valid_o, 0);
    expect_beat("add", 4'd3, 5'd5, 64'd16);
    // rejects and NOP
    issue({7'd0, 10'd0, 3'b000, 5'd1, 7'b0110011}, 4'd1);
    check("rej_op_acc", acc, 0);
    check("rej_op_wb", wb, 0);
    check("rej_ready", x_issue_ready_o, 1);
    issue({7'd1, 10'd0, 3'b000, 5'd1, 7'b0001011}, 4'd1);
    check("rej_f7_acc", acc, 0);
    issue(enc(3'b011, 5'd1), 4'd1);
`ifdef CVXIF_RESP_MUL_EN
    check("mul_acc", acc, 1);
    regs(4'd1, 64'd6, 64'd7);
    commit(4'd1, 0);
    tick(3);
    expect_beat("mul", 4'd1, 5'd1, 64'd42);
`else
    check("mul_rej_acc", acc, 0);
`endif
    issue(enc(3'b100, 5'd1), 4'd1);
    check("rej_f3_acc", acc, 0);
    issue(enc(3'b010, 5'd7), 4'd6);
    check("nop_acc", acc, 1);
    check("nop_wb", wb, 0);
    regs(4'd6, 64'd1, 64'd1);
    commit(4'd6, 0);
    tick(3);
    check("nop_no_beat", beats.size(), 0);
    // fill, wrap, retire order
    do_reset;
    for (int i = 8; i < 12; i++) begin
      check("fill_ready_before", x_issue_ready_o, 1);
      issue(enc(3'b000, 5'(i)), 4'(i));
    end
    check("full_ready", x_issue_ready_o, 0);
    regs(4'd8, 64'd1, 64'd2);
    commit(4'd8, 0);
    check("full_ready_hold", x_issue_ready_o, 0);
    tick(1);
    check("full_ready_free", x_issue_ready_o, 1);
    issue(enc(3'b000, 5'd12), 4'd12);
    check("wrap_acc", acc, 1);
    regs(4'd9, 64'd10, 64'd20);
    regs(4'd10, 64'd100, 64'd1);
    regs(4'd11, 64'd5, 64'd6);
    regs(4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    for (int i = 9; i < 13; i++) commit(4'(i), 0);
    tick(6);
    expect_beat("w8", 4'd8, 5'd8, 64'd3);
    expect_beat("w9", 4'd9, 5'd9, 64'd30);
    expect_beat("w10", 4'd10, 5'd10, 64'd101);
    expect_beat("w11", 4'd11, 5'd11, 64'd11);
    expect_beat("w12", 4'd12, 5'd12, 64'd1);
    // in-order retire despite out-of-order commit
    issue(enc(3'b001, 5'd1), 4'd1);
    issue(enc(3'b000, 5'd2), 4'd2);
    commit(4'd2, 0);
    regs(4'd1, 64'hF0, 64'h3C);
    regs(4'd2, 64'd5, 64'd6);
    tick(3);
    check("ord_wait", beats.size(), 0);
    commit(4'd1, 0);
    tick(4);
    expect_beat("ord1", 4'd1, 5'd1, 64'hCC);
    expect_beat("ord2", 4'd2, 5'd2, 64'd11);
    // kill at head and behind head
    issue(enc(3'b000, 5'd4), 4'd4);
    commit(4'd4, 1);
    tick(2);
    regs(4'd4, 64'd1, 64'd1);
    commit(4'd4, 0);
    tick(3);
    check("kill_head_no_beat", beats.size(), 0);
    issue(enc(3'b000, 5'd5), 4'd5);
    issue(enc(3'b000, 5'd6), 4'd6);
    commit(4'd6, 1);
    regs(4'd5, 64'd2, 64'd3);
    regs(4'd6, 64'd4, 64'd4);
    commit(4'd5, 0);
    commit(4'd6, 0);
    tick(4);
    expect_beat("kill_keep5", 4'd5, 5'd5, 64'd5);
    check("kill_no_extra", beats.size(), 0);
    for (int i = 0; i < 3; i++) issue(enc(3'b000, 5'(i)), 4'(i));
    check("kill_freed_3", x_issue_ready_o, 1);
    issue(enc(3'b000, 5'd3), 4'd3);
    check("kill_freed_4", x_issue_ready_o, 0);
    // same-cycle issue/register/commit for the new id is ignored
    do_reset;
    x_issue_valid_i = 1; x_issue_instr_i = enc(3'b000, 5'd9); x_issue_id_i = 4'd9;
    x_register_valid_i = 1; x_register_id_i = 4'd9; x_register_rs1_i = 64'd1; x_register_rs2_i = 64'd1;
    x_commit_valid_i = 1; x_commit_id_i = 4'd9; x_commit_kill_i = 0;
    tick(1);
    x_issue_valid_i = 0; x_register_valid_i = 0; x_commit_valid_i = 0;
    tick(3);
    check("same_cyc_none", beats.size(), 0);
    regs(4'd9, 64'd50, 64'd50);
    tick(3);
    check("same_cyc_uncommitted", beats.size(), 0);
    commit(4'd9, 0);
    tick(3);
    expect_beat("same_cyc", 4'd9, 5'd9, 64'd100);
    // backpressure hold, then reset drops the pending beat
    do_reset;
    x_result_ready_i = 0;
    issue(enc(3'b000, 5'd3), 4'd7);
    regs(4'd7, 64'd1, 64'd2);
    commit(4'd7, 0);
    tick(2);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", x_result_valid_o, 1);
      check("hold_data", x_result_data_o, 64'd3);
      check("hold_id", x_result_id_o, 4'd7);
      check("hold_rd", x_result_rd_o, 5'd3);
      tick(1);
    end
    rst_ni = 0;
    tick(1);
    check("rst2_valid", x_result_valid_o, 0);
    check("rst2_ready", x_issue_ready_o, 1);
    rst_ni = 1;
    x_result_ready_i = 1;
    tick(3);
    check("rst2_no_beat", beats.size(), 0);
    for (int i = 0; i < 3; i++) issue(enc(3'b000, 5'(i)), 4'(i));
    check("rst2_cleared_3", x_issue_ready_o, 1);
    issue(enc(3'b000, 5'd3), 4'd3);
    check("rst2_cleared_4", x_issue_ready_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cvxif_issue_responder.md
CVXIF_ISSUE_RESPONDER -- requirements
Module: cvxif_issue_responder

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width.
REQ-002 SHALL have parameter ID_W, default 4, transaction-id width.
REQ-003 SHALL have parameter DEPTH, default 4, in-flight table entries (power of two, >=2).
REQ-004 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, synchronous, active-low.
REQ-005 SHALL have ports x_issue_valid_i in 1, x_issue_ready_o out 1, x_issue_instr_i in 32, x_issue_id_i in ID_W: issue request.
REQ-006 SHALL have ports x_issue_accept_o out 1, x_issue_writeback_o out 1: issue response, valid while x_issue_valid_i.
REQ-007 SHALL have ports x_register_valid_i in 1, x_register_ready_o out 1, x_register_id_i in ID_W, x_register_rs1_i in XLEN, x_register_rs2_i in XLEN: operands.
REQ-008 SHALL have ports x_commit_valid_i in 1, x_commit_id_i in ID_W, x_commit_kill_i in 1: commit/kill.
REQ-009 SHALL have ports x_result_valid_o out 1, x_result_ready_i in 1, x_result_id_o out ID_W, x_result_data_o out XLEN, x_result_rd_o out 5, x_result_we_o out 1: result.

Function
REQ-010 SHALL decode opcode 7'b0001011 (custom-0) with funct7=0; funct3 000 ADD, 001 XOR, 010 NOP; all else rejected.
REQ-011 x_issue_ready_o SHALL be 1 iff occupied entries < DEPTH, from registered count only (no same-cycle retire bypass).
REQ-012 On issue handshake with accepted instr: allocate tail entry {id, rd, funct3, have_ops=0, committed=0}; accept=1; writeback=1 for ADD/XOR, 0 for NOP.
REQ-013 Rejected instr: handshake completes, accept=0, writeback=0, no entry allocated.
REQ-014 x_register_ready_o SHALL be constant 1; on valid, entry with matching id captures rs1/rs2, sets have_ops; unmatched id ignored.
REQ-015 On x_commit_valid_i: matching entry sets committed if kill=0; frees entry (no result) if kill=1; unmatched ignored.
REQ-016 Entries SHALL retire strictly in allocation order; head retires when have_ops & committed & result register free (or being drained this cycle).
REQ-017 NOP head SHALL free silently without a result beat.
REQ-018 ADD/XOR head SHALL load result register: data = rs1+rs2 (mod 2^XLEN) or rs1^rs2, id, rd, we=1; latency 1 cycle from retire condition to x_result_valid_o.
REQ-019 x_result_* SHALL hold stable while valid & !ready; valid drops cycle after handshake unless new result loaded.
REQ-020 Killed non-head entries SHALL be marked dead and skipped when reaching head, same cycle as freed.
REQ-021 Simultaneous issue, register, commit and retire in one cycle SHALL all take effect; register/commit for id issued same cycle ignored.
REQ-022 Head/tail pointers SHALL wrap modulo DEPTH; full (DEPTH) and empty (0) distinguished by count.

Reset
REQ-023 rst_ni low at clk_i edge SHALL clear all entries, pointers, count, result register; x_result_valid_o=0, x_issue_ready_o=1 next cycle.
REQ-024 Reset mid-transaction SHALL drop in-flight entries and pending result without output beat.

Configuration
REQ-025 Macro CVXIF_RESP_MUL_EN defined: funct3 011 MUL accepted, writeback=1, result low XLEN bits of rs1*rs2.
REQ-026 Macro undefined: funct3 011 rejected per REQ-013; no multiplier instantiated.

Structure
REQ-027 Package cvxif_resp_pkg SHALL hold opcode/funct3 constants, op enum, entry struct typedef.
REQ-028 Sub-module cvxif_resp_alu SHALL hold combinational ADD/XOR/(MUL) datapath.

Verification
REQ-029 Issue ADD id=3 rd=5, register rs1=7 rs2=9, commit kill=0 -> accept=1 wb=1; result id=3 rd=5 data=16 we=1.
REQ-030 Issue opcode 7'b0110011 -> accept=0, wb=0, count unchanged, ready stays 1.
REQ-031 Issue 4 accepted instrs (DEPTH=4) -> ready=0; retire one -> ready=1 following cycle; 5th issue then allocates at wrapped index 0.
REQ-032 Issue XOR id=1 then ADD id=2, commit id=2 first, ops both, commit id=1 -> results emitted id=1 then id=2.
REQ-033 Issue ADD id=4, commit kill=1 before operands -> no result beat, entry freed, later register id=4 ignored.
REQ-034 Hold x_result_ready_i=0 five cycles with result pending -> outputs stable; assert rst_ni=0 -> valid=0 next cycle, all state cleared.
